// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO draining into a UART transmitter with send/ack handshake
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     busy,
    output logic [7:0]               send_data,
    output logic                     send_req,
    input  logic                     uart_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    localparam logic [PW:0]   LVL_FULL = DEPTH[PW:0];
    localparam logic [PW:0]   LVL_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_HIGH = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;

    assign wr_ready = (level != LVL_FULL);
    assign push     = wr_en && wr_ready;
    assign pop      = (state == IDLE) && (level != '0) && uart_ready;
    assign busy     = (level != '0) || (state != IDLE);

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            // A dropped write wins over a simultaneous clear.
            if (wr_en && !wr_ready) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            cnt       <= '0;
            send_req  <= 1'b0;
            send_data <= 8'h00;
        end else begin
            send_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        send_data <= mem[rd_ptr];
                        send_req  <= 1'b1;
                        rd_ptr    <= rd_ptr + PTR_ONE;
                        cnt       <= '0;
                        state     <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    // A UART that never acknowledges is treated as having sent the byte.
                    if (!uart_ready) begin
                        state <= WAIT_HIGH;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (uart_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [4:0] level;
    logic       overflow;
    logic       clr_overflow;
    logic       busy;
    logic [7:0] send_data;
    logic       send_req;
    logic       uart_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int mode  = 2;   // 0: ack for 10 cycles, 1: held low, 2: held high
    int hold  = 0;
    logic [7:0] rx_q [$];
    int         t_q  [$];

    uart_tx_fifo #(.DEPTH(16), .ACK_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .busy         (busy),
        .send_data    (send_data),
        .send_req     (send_req),
        .uart_ready   (uart_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model and pulse monitor, evaluated mid-cycle
    always @(negedge clk) begin
        if (send_req) begin
            rx_q.push_back(send_data);
            t_q.push_back(cyc);
        end
        if (mode == 1) begin
            uart_ready = 1'b0;
            hold = 0;
        end else if (mode == 2) begin
            uart_ready = 1'b1;
            hold = 0;
        end else if (hold > 0) begin
            hold = hold - 1;
            if (hold == 0) uart_ready = 1'b1;
        end else if (send_req) begin
            uart_ready = 1'b0;
            hold = 10;
        end else begin
            uart_ready = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int wcyc;
        int n;
        reset = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        clr_overflow = 1'b0;
        mode = 2;
        repeat (3) tick();
        check("rst_level", level, 0);
        check("rst_send_req", send_req, 0);
        check("rst_send_data", send_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_ready", wr_ready, 1);
        reset = 1'b0;
        tick();

        // Basic transfer: pulse 2 edges after the write edge, one cycle wide
        mode = 0;
        tick();
        write_byte(8'h41);
        check("basic_level", level, 1);
        check("basic_req_early", send_req, 0);
        tick();
        check("basic_req", send_req, 1);
        check("basic_data", send_data, 8'h41);
        tick();
        check("basic_req_width", send_req, 0);
        wait_idle(50, "basic_idle");
        check("basic_ready", uart_ready, 1);
        check("basic_count", rx_q.size(), 1);
        check("basic_rx", rx_q[0], 8'h41);
        check("basic_data_hold", send_data, 8'h41);

        // Ordering and wrap-around over 40 paced bytes
        base = rx_q.size();
        for (int i = 0; i < 40; i++) begin
            write_byte(8'(i));
            wait_idle(40, "order_idle");
        end
        check("order_count", rx_q.size(), base + 40);
        for (int i = 0; i < 40; i++) begin
            if (base + i < rx_q.size()) check("order_data", rx_q[base + i], i);
        end
        check("order_overflow", overflow, 0);

        // Fill, overflow, clear precedence
        mode = 1;
        tick();
        base = rx_q.size();
        for (int i = 0; i < 16; i++) write_byte(8'h50 + 8'(i));
        check("full_level", level, 16);
        check("full_wr_ready", wr_ready, 0);
        check("full_overflow_pre", overflow, 0);
        write_byte(8'hEE);
        check("drop_level", level, 16);
        check("drop_overflow", overflow, 1);
        wr_en = 1'b1;
        wr_data = 8'hEF;
        clr_overflow = 1'b1;
        tick();
        wr_en = 1'b0;
        clr_overflow = 1'b0;
        check("clr_vs_set", overflow, 1);
        check("clr_vs_set_level", level, 16);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("clr_alone", overflow, 0);
        check("full_no_pulse", rx_q.size(), base);
        mode = 0;
        wait_idle(400, "full_drain_idle");
        check("full_drain_count", rx_q.size(), base + 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < rx_q.size()) check("full_drain_data", rx_q[base + i], 8'h50 + i);
        end

        // Timeout: UART never acknowledges
        mode = 2;
        tick();
        base = rx_q.size();
        write_byte(8'hA1);
        wcyc = cyc;
        write_byte(8'hA2);
        wait_idle(100, "tmo_idle");
        check("tmo_count", rx_q.size(), base + 2);
        if (rx_q.size() >= base + 2) begin
            check("tmo_data0", rx_q[base], 8'hA1);
            check("tmo_data1", rx_q[base + 1], 8'hA2);
            check("tmo_latency", t_q[base] - wcyc, 1);
            check("tmo_spacing", t_q[base + 1] - t_q[base], 16);
        end

        // Reset during WAIT_HIGH discards the queue
        mode = 0;
        tick();
        base = rx_q.size();
        for (int i = 0; i < 5; i++) write_byte(8'h61 + 8'(i));
        n = 0;
        while (rx_q.size() == base && n < 20) begin
            tick();
            n++;
        end
        check("rst_mid_pulse", rx_q.size(), base + 1);
        if (rx_q.size() > base) check("rst_mid_data", rx_q[base], 8'h61);
        tick();
        check("rst_mid_ready_low", uart_ready, 0);
        reset = 1'b1;
        #1;
        check("rst_mid_level", level, 0);
        check("rst_mid_send_req", send_req, 0);
        tick();
        check("rst_mid_busy", busy, 0);
        reset = 1'b0;
        repeat (40) tick();
        check("rst_mid_silent", rx_q.size(), base + 1);
        write_byte(8'h77);
        wait_idle(60, "rst_mid_idle");
        check("rst_mid_new_count", rx_q.size(), base + 2);
        if (rx_q.size() >= base + 2) check("rst_mid_new_data", rx_q[base + 1], 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving the FIFO depth in bytes; DEPTH SHALL be a power of two, >=2.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, giving the maximum cycles to wait for the UART to drop uart_ready after a send.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  bus write strobe for one byte; one byte is offered per cycle while high.
REQ-007 wr_data  input  8  byte to enqueue.
REQ-008 wr_ready  output  1  high when the FIFO is not full.
REQ-009 level  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
REQ-010 overflow  output  1  sticky flag, set when a write is dropped.
REQ-011 clr_overflow  input  1  clears overflow.
REQ-012 busy  output  1  high when level!=0 or the drain FSM is not IDLE.
REQ-013 send_data  output  8  byte presented to the UART transmitter.
REQ-014 send_req  output  1  one-cycle send pulse to the UART transmitter.
REQ-015 uart_ready  input  1  UART transmitter idle/ready indication.

Function
REQ-016 SHALL accept a write on a clock edge where wr_en=1 and wr_ready=1, store wr_data at the write pointer, and increment the write pointer modulo DEPTH.
REQ-017 SHALL drop a write when wr_en=1 and the FIFO is full, leaving contents, pointers and level unchanged, and SHALL set overflow.
REQ-018 SHALL derive wr_ready combinationally as level!=DEPTH; a pop in the same cycle SHALL NOT make a write to a full FIFO succeed.
REQ-019 SHALL update level as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-020 On an edge where both the set and clear conditions for overflow hold, SHALL leave overflow set.
REQ-021 The drain FSM SHALL have the states IDLE, WAIT_LOW and WAIT_HIGH.
REQ-022 In IDLE with level!=0 and uart_ready=1, the FSM SHALL, on the next edge, register send_data from the head entry, set send_req=1, advance the read pointer modulo DEPTH (pop), clear the timeout counter, and enter WAIT_LOW.
REQ-023 send_req SHALL be high for exactly one cycle per popped byte and SHALL never be high outside the cycle following an IDLE pop.
REQ-024 In WAIT_LOW, the FSM SHALL enter WAIT_HIGH when uart_ready=0; otherwise it SHALL increment the counter, and on reaching ACK_TIMEOUT it SHALL return to IDLE, treating the byte as sent.
REQ-025 In WAIT_HIGH, the FSM SHALL return to IDLE when uart_ready=1.
REQ-026 send_data SHALL hold its value until the next pop.
REQ-027 Latency: a byte accepted at edge N into an empty FIFO, with FSM IDLE and uart_ready=1, SHALL produce send_req=1 in the cycle after edge N+1.
REQ-028 Bytes SHALL be emitted in strict write order with no loss except REQ-017 drops.
REQ-029 Wrap-around: pointers SHALL wrap from DEPTH-1 to 0 with no change in ordering.
REQ-030 busy SHALL be combinational from level and FSM state.

Reset
REQ-031 While reset=1, SHALL force level=0, both pointers=0, FSM=IDLE, send_req=0, send_data=0, overflow=0, and the timeout counter=0.
REQ-032 Reset asserted mid-transfer SHALL discard all queued bytes and SHALL NOT emit send_req until a new byte is written after release.
REQ-033 FIFO storage contents need no reset.

Verification
REQ-034 Basic transfer: write 0x41 into an empty FIFO with uart_ready=1 -> send_req pulses once, 2 cycles after the write edge, with send_data=0x41; the bench model drops uart_ready for 10 cycles; busy=0 after uart_ready returns high.
REQ-035 Ordering and wrap: with DEPTH=16, write 40 bytes 0x00..0x27 paced at most 1 per UART completion -> exactly 40 pulses carrying 0x00..0x27 in order, and overflow stays 0.
REQ-036 Full and overflow: hold uart_ready=0 and write 17 bytes -> level=16, wr_ready=0, byte 17 dropped, overflow=1; assert clr_overflow together with an 18th write -> overflow stays 1; assert clr_overflow alone -> overflow=0.
REQ-037 Timeout: the UART model never drops uart_ready -> the FSM returns to IDLE 15 cycles after send_req, and the next byte is sent.
REQ-038 Reset mid-operation: queue 5 bytes, assert reset during WAIT_HIGH -> level=0, send_req=0, no further pulses after release until a new write occurs.
